// File: rtl/accu_sched_pkg.sv
// Shared types and default sizing for the accumulation scheduler.
package accu_sched_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_BURST  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

endpackage

// File: rtl/accu_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester found after last_grant wins.
module rr_arbiter #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last_grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              any_req
);

  logic [CH_W-1:0] idx;

  always_comb begin
    grant_idx = '0;
    any_req   = 1'b0;
    idx       = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = CH_W'((int'(last_grant) + i) % NUM_CH);
      if (!any_req && req[idx]) begin
        any_req   = 1'b1;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/accu_sched.sv
// Round-robin scheduler sharing one BURST-beat accumulator among NUM_CH channels.
//
// state  | meaning
// IDLE   | waiting for any request; arbitration result registered into grant
// ACCUM  | granted channel locked, summing BURST accepted beats
// OUTPUT | burst sum held on out_* until downstream accepts it
module accu_sched
  import accu_sched_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int BURST  = DEF_BURST,
  localparam int SUM_W  = DATA_W + $clog2(BURST),
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*DATA_W-1:0] req_data,
  output logic [NUM_CH-1:0]        req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SUM_W-1:0]         out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     busy
);

  localparam int CNT_W = $clog2(BURST);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   grant_q, last_grant_q, arb_idx;
  logic              any_req;
  logic [CNT_W-1:0]  cnt_q;
  logic [SUM_W-1:0]  sum_q, sum_next;
  logic [DATA_W-1:0] beat_data;
  logic              beat, last_beat;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant_idx  (arb_idx),
    .any_req    (any_req)
  );

  always_comb begin
    beat_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_q == CH_W'(i)) beat_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign beat      = (state_q == ACCUM) && req_valid[grant_q];
  assign last_beat = beat && (cnt_q == CNT_W'(BURST - 1));
  assign sum_next  = (cnt_q == '0) ? SUM_W'(beat_data) : sum_q + SUM_W'(beat_data);
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Ready is decoded from state/grant registers only, never from req_valid.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    case (state_q)
      IDLE:   if (any_req) state_d = ACCUM;
      ACCUM: begin
        req_ready[grant_q] = 1'b1;
        if (last_beat) state_d = OUTPUT;
      end
      OUTPUT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q      <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      cnt_q        <= '0;
      sum_q        <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_ch       <= '0;
    end else begin
      if (state_q == IDLE && any_req) grant_q <= arb_idx;
      if (beat) begin
        sum_q <= sum_next;
        cnt_q <= cnt_q + 1'b1;
      end
      if (last_beat) begin
        out_valid <= 1'b1;
        out_data  <= sum_next;
        out_ch    <= grant_q;
      end
      if (state_q == OUTPUT && out_ready) begin
        out_valid    <= 1'b0;
        last_grant_q <= grant_q;
        cnt_q        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_accu_sched.sv
// Bench for accu_sched: transaction-level reference model plus directed and random scenarios.
module tb_accu_sched;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int BL  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NCH-1:0]  req_valid;
  logic [NCH*DW-1:0] req_data;
  logic [NCH-1:0]  req_ready;
  logic            out_valid, out_ready;
  logic [9:0]      out_data;
  logic [1:0]      out_ch;
  logic            busy;

  accu_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Sources: per-channel sample queues, popped when a handshake happened.
  int src [NCH][$];
  int acc_cnt [NCH];
  int bub_at [NCH];
  int bub_len [NCH];
  bit acc_flag [NCH];
  bit drv_en = 0;
  bit rand_ready = 0;
  int gap_pct = 0;

  // Logs of completed bursts: from the DUT handshake and from the model.
  int log_ch[$], log_data[$];
  int exp_ch[$], exp_data[$];

  // Reference model: arbitration order, beat list, held result.
  int m_phase, m_owner, m_last, m_data, m_ch;
  int m_beats[$];

  function automatic int rr_pick(logic [NCH-1:0] r, int last);
    for (int i = 1; i <= NCH; i++)
      if (r[(last + i) % NCH]) return (last + i) % NCH;
    return 0;
  endfunction

  function automatic int qsum(int q[$]);
    int s = 0;
    foreach (q[i]) s += q[i];
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_last = NCH - 1; m_beats.delete(); m_data = 0; m_ch = 0; m_owner = 0;
    end else begin
      case (m_phase)
        0: if (req_valid != 0) begin m_owner = rr_pick(req_valid, m_last); m_phase = 1; end
        1: if (req_valid[m_owner]) begin
             m_beats.push_back(int'(req_data[m_owner*DW +: DW]));
             if (m_beats.size() == BL) begin
               m_data = qsum(m_beats); m_ch = m_owner; m_beats.delete();
               exp_ch.push_back(m_ch); exp_data.push_back(m_data);
               m_phase = 2;
             end
           end
        default: if (out_ready) begin m_last = m_owner; m_phase = 0; end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [NCH-1:0] er;
    for (int c = 0; c < NCH; c++) acc_flag[c] = req_valid[c] && req_ready[c];
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_ch", out_ch, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
    end else begin
      er = '0;
      if (m_phase == 1) er[m_owner] = 1'b1;
      chk("busy", busy, m_phase != 0);
      chk("req_ready", req_ready, er);
      chk("out_valid", out_valid, m_phase == 2);
      if (m_phase == 2) begin
        chk("out_data", out_data, m_data);
        chk("out_ch", out_ch, m_ch);
      end
      if (out_valid && out_ready) begin
        log_ch.push_back(int'(out_ch)); log_data.push_back(int'(out_data));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = 1'($urandom_range(1));
      if (drv_en) begin
        for (int c = 0; c < NCH; c++) begin
          if (rst_n && acc_flag[c] && src[c].size() > 0) begin
            void'(src[c].pop_front());
            acc_cnt[c]++;
          end
          if (acc_cnt[c] == bub_at[c] && bub_len[c] > 0) begin
            req_valid[c] = 1'b0; bub_len[c]--;
          end else if (src[c].size() > 0 && $urandom_range(99) >= gap_pct) begin
            req_valid[c] = 1'b1; req_data[c*DW +: DW] = 8'(src[c][0]);
          end else req_valid[c] = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    for (int c = 0; c < NCH; c++) begin src[c].delete(); bub_len[c] = 0; end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_log(int n, int limit, string name);
    int k = 0;
    while (log_ch.size() < n && k < limit) begin @(negedge clk); k++; end
    chk(name, log_ch.size() >= n, 1);
  endtask

  task automatic chk_log(int idx, int ech, int edata, string name);
    if (log_ch.size() > idx) begin
      chk({name, "_ch"}, log_ch[idx], ech);
      chk({name, "_data"}, log_data[idx], edata);
    end
  endtask

  initial begin
    int base, k, a0, total, ebase;
    int e3[4];
    int e5c[4], e5d[4];
    rst_n = 1'b0; out_ready = 1'b0; req_valid = '0; req_data = '0;
    for (int c = 0; c < NCH; c++) begin acc_cnt[c] = 0; bub_at[c] = -1; bub_len[c] = 0; end

    // 1: reset with random inputs, then idle with no requests
    repeat (3) begin
      @(posedge clk); #1;
      req_valid = 4'($urandom); req_data = $urandom; out_ready = 1'($urandom_range(1));
      @(negedge clk);
      chk("t1_out_valid", out_valid, 0);
      chk("t1_req_ready", req_ready, 0);
    end
    @(posedge clk); #1 req_valid = '0; out_ready = 1'b1;
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t1_idle_busy", busy, 0);
      chk("t1_idle_ready", req_ready, 0);
    end
    drv_en = 1;

    // 2: single channel latency and sum
    @(posedge clk);
    src[1].push_back(10); src[1].push_back(20); src[1].push_back(30); src[1].push_back(40);
    @(negedge clk);
    chk("t2_c0_ready", req_ready, 0);
    chk("t2_c0_busy", busy, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("t2_ready_beat", req_ready, 4'b0010);
    end
    @(negedge clk);
    chk("t2_out_valid", out_valid, 1);
    chk("t2_out_data", out_data, 100);
    chk("t2_out_ch", out_ch, 1);
    @(negedge clk);
    chk("t2_busy_low", busy, 0);

    // 3: contention among all channels
    do_reset();
    base = log_ch.size();
    @(posedge clk);
    for (int c = 0; c < NCH; c++) repeat (BL) src[c].push_back(c == 2 ? 255 : 1);
    wait_log(base + 4, 200, "t3_timeout");
    e3 = '{4, 4, 1020, 4};
    for (int i = 0; i < 4; i++) chk_log(base + i, i, e3[i], "t3");

    // 4: bubble after beat 2, then output backpressure
    do_reset();
    out_ready = 1'b0;
    base = log_ch.size();
    bub_at[0] = acc_cnt[0] + 2; bub_len[0] = 2;
    @(posedge clk);
    src[0].push_back(11); src[0].push_back(22); src[0].push_back(33); src[0].push_back(44);
    k = 0;
    while (!out_valid && k < 100) begin @(negedge clk); k++; end
    chk("t4_valid_timeout", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t4_hold_data", out_data, 110);
      chk("t4_hold_ch", out_ch, 0);
      chk("t4_hold_ready", req_ready, 0);
      if (i < 2) @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_log(base + 1, 20, "t4_timeout");
    chk_log(base, 0, 110, "t4");

    // 5: fairness between two continuous requesters
    do_reset();
    base = log_ch.size();
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin src[0].push_back(i + 1); src[3].push_back(100 + i); end
    wait_log(base + 4, 400, "t5_timeout");
    e5c = '{0, 3, 0, 3};
    e5d = '{10, 406, 26, 422};
    for (int i = 0; i < 4; i++) chk_log(base + i, e5c[i], e5d[i], "t5");

    // 6: reset in the middle of a burst discards the partial sum
    do_reset();
    a0 = acc_cnt[2];
    @(posedge clk);
    src[2].push_back(5); src[2].push_back(5);
    k = 0;
    while (acc_cnt[2] < a0 + 2 && k < 50) begin @(negedge clk); k++; end
    chk("t6_beats_timeout", acc_cnt[2] >= a0 + 2, 1);
    #1 rst_n = 1'b0;
    src[2].delete();
    base = log_ch.size();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    repeat (BL) src[2].push_back(7);
    wait_log(base + 1, 100, "t6_timeout");
    chk_log(base, 2, 28, "t6");

    // Random traffic with bubbles and random backpressure
    do_reset();
    base = log_ch.size(); ebase = exp_ch.size();
    gap_pct = 30; rand_ready = 1;
    total = 0;
    @(posedge clk);
    for (int c = 0; c < NCH; c++) begin
      int nb = $urandom_range(1, 4);
      total += nb;
      repeat (nb * BL) src[c].push_back($urandom_range(255));
    end
    wait_log(base + total, 3000, "rnd_timeout");
    rand_ready = 0; gap_pct = 0;
    @(posedge clk); #1 out_ready = 1'b1;
    chk("rnd_count", log_ch.size() - base, exp_ch.size() - ebase);
    for (int i = 0; i < total; i++)
      if (exp_ch.size() > ebase + i) chk_log(base + i, exp_ch[ebase + i], exp_data[ebase + i], "rnd");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
